speck_cipher_core: RTL
======================

Name: speck_cipher_core

Overview:
- Next-generation Speck block cipher core: encrypt and decrypt selectable per block, configurable word size and round count, and UNROLL rounds evaluated per clock.
- Valid/ready handshakes on both input and output; the result is held until the consumer accepts it.
- Takes a precomputed flat round-key vector from the key-schedule stage and sits between the UART frame parser and the response formatter.

Parameters:
- W, 32, word size in bits (16/24/32/48/64).
- ROUNDS, 27, total rounds.
- UNROLL, 1, rounds per clock. Must divide ROUNDS exactly; elaboration error otherwise.
- ALPHA, (W==16 ? 7 : 8), right-rotate amount applied to x.
- BETA, (W==16 ? 2 : 3), left-rotate amount applied to y.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input block present.
- in_ready  out  1  core can accept a block this cycle.
- in_decrypt  in  1  0=encrypt, 1=decrypt; sampled on accept.
- in_x  in  W  input word x (plaintext or ciphertext).
- in_y  in  W  input word y.
- rk_flat  in  W*ROUNDS  round keys; key i occupies bits [i*W +: W].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_x  out  W  result word x.
- out_y  out  W  result word y.
- out_decrypt  out  1  mode of the block currently on out_x/out_y.
- busy  out  1  high while rounds are in progress.

Behaviour:
- Reset (async, any state, including mid-block): state=IDLE; x, y, round counter, out_x, out_y, out_decrypt, out_valid and busy all 0. An in-flight block is discarded. in_ready is 1 after reset.
- Encrypt round with key k:
  - x' = (ROR(x,ALPHA) + y) ^ k, addition mod 2^W.
  - y' = ROL(y,BETA) ^ x'.
  - Keys are used in order 0 .. ROUNDS-1.
- Decrypt round with key k:
  - y' = ROR(x ^ y, BETA).
  - x' = ROL((x ^ k) - y', ALPHA), subtraction mod 2^W.
  - Keys are used in order ROUNDS-1 .. 0.
- Datapath: UNROLL round stages chained combinationally each cycle. Stage j uses key index base+j (encrypt) or base-j (decrypt).
- Step counter runs 0 .. NSTEP-1, with NSTEP = ROUNDS/UNROLL. Key base index:
  - encrypt: step*UNROLL.
  - decrypt: ROUNDS-1-step*UNROLL.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_x/in_y/in_decrypt, clear step, set busy, go to RUN.
  - RUN: each edge applies UNROLL rounds. On the edge where step==NSTEP-1, write the result to out_x/out_y, set out_valid=1, clear busy, go to DONE.
  - DONE: outputs held stable while out_ready=0. When out_ready=1, out_valid falls at the next edge.
    - If in_valid is also 1 in that cycle, the new block is accepted on the same edge and the FSM goes directly to RUN.
    - Otherwise the FSM goes to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from out_ready; no other combinational in-to-out paths.
- Latency: accept on edge T gives out_valid=1 after edge T+NSTEP. Examples: 27 cycles for UNROLL=1; 9 cycles for UNROLL=3 with ROUNDS=27.
- Throughput: one block per NSTEP+1 cycles when out_ready is held 1.
- in_valid in RUN is ignored and no block is accepted.
- rk_flat must be stable from the accept edge until out_valid rises. The core does not latch it.
- out_decrypt is latched together with the data.
- Counter width is $clog2(NSTEP)+1. Key index arithmetic must not wrap for any legal parameter set.

Test Plan:
- Speck64/128 encrypt:
  - Key 1b1a1918 13121110 0b0a0908 03020100, round keys from the bench model.
  - Stimulus: in_x=3b726574, in_y=7475432d, in_decrypt=0.
  - Required: out_x=8c6fa548, out_y=454e028b, out_valid exactly 27 cycles after accept.
- Decrypt with the same keys:
  - Stimulus: in_x=8c6fa548, in_y=454e028b, in_decrypt=1.
  - Required: out_x=3b726574, out_y=7475432d, out_decrypt=1.
- UNROLL=3 build, same vectors:
  - Required: identical results; out_valid 9 cycles after accept; busy high for exactly 9 cycles.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid; drive in_valid=1 throughout.
  - Required: out_x/out_y stable; in_ready=0 until out_ready=1; the second block is accepted on the same edge out_valid falls; its result is correct.
- Reset mid-operation:
  - Stimulus: assert rst at round 13.
  - Required: all outputs 0 immediately (asynchronously), in_ready=1 after release. A fresh encrypt then yields 8c6fa548/454e028b.
- Speck32/64 (W=16, ROUNDS=22):
  - Key 1918 1110 0908 0100, pt 6574 694c.
  - Required: ct a868 42f2; decrypt of that ct restores 6574 694c.

Source files
------------

// File: rtl/speck_cipher_core.sv
// Speck block cipher core: encrypt/decrypt per block, UNROLL rounds per clock,
// valid/ready on both sides with the result held until accepted.
module speck_cipher_core #(
    parameter int W      = 32,
    parameter int ROUNDS = 27,
    parameter int UNROLL = 1,
    parameter int ALPHA  = (W == 16) ? 7 : 8,
    parameter int BETA   = (W == 16) ? 2 : 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_decrypt,
    input  logic [W-1:0]          in_x,
    input  logic [W-1:0]          in_y,
    input  logic [W*ROUNDS-1:0]   rk_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_x,
    output logic [W-1:0]          out_y,
    output logic                  out_decrypt,
    output logic                  busy
);

    localparam int NSTEP = ROUNDS / UNROLL;
    localparam int CW    = $clog2(NSTEP) + 1;
    localparam int KB    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    if (UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
        $error("UNROLL must be >= 1 and divide ROUNDS");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [W-1:0]    x, y;
    logic [CW-1:0]   step;
    logic            mode;
    logic            accept, last;

    logic [W-1:0]    rk [ROUNDS];
    logic [W-1:0]    sx [UNROLL+1];
    logic [W-1:0]    sy [UNROLL+1];
    logic [W-1:0]    k, nx, ny;
    int              ki;

    for (genvar i = 0; i < ROUNDS; i++) begin : g_rk
        assign rk[i] = rk_flat[i*W +: W];
    end

    function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int n);
        return (v << n) | (v >> (W - n));
    endfunction

    function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int n);
        return (v >> n) | (v << (W - n));
    endfunction

    // Combinational chain of UNROLL rounds starting from the registered state
    always_comb begin
        sx[0] = x;
        sy[0] = y;
        k     = '0;
        nx    = '0;
        ny    = '0;
        ki    = 0;
        for (int j = 0; j < UNROLL; j++) begin
            if (mode)
                ki = ROUNDS - 1 - int'(step) * UNROLL - j;
            else
                ki = int'(step) * UNROLL + j;
            k = rk[KB'(ki)];
            if (mode) begin
                ny = ror(sx[j] ^ sy[j], BETA);
                nx = rol((sx[j] ^ k) - ny, ALPHA);
            end else begin
                nx = (ror(sx[j], ALPHA) + sy[j]) ^ k;
                ny = rol(sy[j], BETA) ^ nx;
            end
            sx[j+1] = nx;
            sy[j+1] = ny;
        end
    end

    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign last     = (state == RUN) && (step == CW'(NSTEP - 1));

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = RUN;
            RUN:  if (last) state_next = DONE;
            DONE: if (out_ready) state_next = in_valid ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            step        <= '0;
            mode        <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            out_decrypt <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DONE && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                x    <= in_x;
                y    <= in_y;
                mode <= in_decrypt;
                step <= '0;
                busy <= 1'b1;
            end else if (state == RUN) begin
                x <= sx[UNROLL];
                y <= sy[UNROLL];
                if (last) begin
                    out_x       <= sx[UNROLL];
                    out_y       <= sy[UNROLL];
                    out_decrypt <= mode;
                    out_valid   <= 1'b1;
                    busy        <= 1'b0;
                end else begin
                    step <= step + CW'(1);
                end
            end
        end
    end

endmodule
